// File: rtl/sdrc_bist.sv
// sdrc_bist: SDRAM-controller self test. It writes pattern bursts, reads them back and counts
// miscompares. Watchdog, abort and sticky done/pass status are included.
module sdrc_bist #(
   parameter int APP_AW = 26,
   parameter int APP_DW = 32,
   parameter int ERR_W  = 16,
   parameter int TMO    = 4096
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                abort,
   input  logic [1:0]          cfg_mode,
   input  logic [APP_AW-1:0]   cfg_start_addr,
   input  logic [APP_AW-1:0]   cfg_addr_stride,
   input  logic [8:0]          cfg_burst_len,
   input  logic [15:0]         cfg_num_bursts,
   output logic                app_req,
   output logic [APP_AW-1:0]   app_req_addr,
   output logic [8:0]          app_req_len,
   output logic                app_req_wr_n,
   input  logic                app_req_ack,
   output logic [APP_DW-1:0]   app_wr_data,
   output logic [APP_DW/8-1:0] app_wr_en_n,
   input  logic                app_wr_next_req,
   input  logic                app_rd_valid,
   input  logic [APP_DW-1:0]   app_rd_data,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [ERR_W-1:0]    err_cnt,
   output logic [APP_AW-1:0]   first_err_addr,
   output logic                timeout,
   output logic                cfg_err
);
   localparam int WDW = $clog2(TMO + 1);
   localparam logic [APP_DW-1:0] CHK = {(APP_DW/2){2'b01}};
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA, NEXT, DONE} state_t;
   state_t state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic [APP_AW-1:0] addr_q, addr_d, stride_q, stride_d, first_err_addr_q, first_err_addr_d;
   logic [8:0] len_q, len_d, idx_q, idx_d;
   logic [15:0] nb_q, nb_d, b_q, b_d;
   logic [31:0] lfsr_q, lfsr_d, lfsr_nx, seed, inc_w;
   logic [WDW-1:0] wdog_q, wdog_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic done_q, done_d, pass_q, pass_d, timeout_q, timeout_d, cfg_err_q, cfg_err_d;
   logic [APP_DW-1:0] word;
   logic active, progress, last;
   assign active   = state_q == WR_REQ || state_q == WR_DATA || state_q == RD_REQ || state_q == RD_DATA;
   assign progress = app_req_ack | app_wr_next_req | app_rd_valid;
   assign last     = idx_q == len_q - 9'd1;
   assign seed     = {b_q, ~b_q};
   assign lfsr_nx  = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
   assign inc_w    = {b_q, 16'h0} + 32'(idx_q);
   // Current word is regenerated from (burst, index); the LFSR register tracks word idx_q.
   assign word = mode_q == 2'd0 ? APP_DW'(inc_w) :
                 mode_q == 2'd1 ? APP_DW'(lfsr_q) :
                 mode_q == 2'd2 ? APP_DW'(1) << ((32'(b_q) + 32'(idx_q)) % APP_DW) :
                 (idx_q[0] ? ~CHK : CHK);
   assign app_req        = state_q == WR_REQ || state_q == RD_REQ;
   assign app_req_wr_n   = state_q != WR_REQ;
   assign app_req_addr   = addr_q;
   assign app_req_len    = len_q;
   assign app_wr_data    = state_q == WR_DATA ? word : '0;
   assign app_wr_en_n    = {(APP_DW/8){state_q != WR_DATA}};
   assign busy           = state_q != IDLE && state_q != DONE;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_err_addr_q;
   assign timeout        = timeout_q;
   assign cfg_err        = cfg_err_q;
   always_comb begin
      state_d = state_q;
      mode_d = mode_q;
      addr_d = addr_q;
      stride_d = stride_q;
      len_d = len_q;
      nb_d = nb_q;
      b_d = b_q;
      idx_d = idx_q;
      lfsr_d = lfsr_q;
      err_cnt_d = err_cnt_q;
      first_err_addr_d = first_err_addr_q;
      done_d = done_q;
      pass_d = pass_q;
      timeout_d = timeout_q;
      cfg_err_d = cfg_err_q;
      wdog_d = active && !progress ? wdog_q + 1'b1 : '0;
      if (abort) begin
         state_d = IDLE;
         wdog_d = '0;
      end else begin
         case (state_q)
            IDLE, DONE: if (start) begin
               mode_d = cfg_mode;
               addr_d = cfg_start_addr;
               stride_d = cfg_addr_stride;
               len_d = cfg_burst_len;
               nb_d = cfg_num_bursts;
               b_d = '0;
               idx_d = '0;
               err_cnt_d = '0;
               first_err_addr_d = '0;
               timeout_d = 1'b0;
               cfg_err_d = cfg_burst_len == '0;
               done_d = cfg_burst_len == '0 || cfg_num_bursts == '0;
               pass_d = cfg_burst_len != '0 && cfg_num_bursts == '0;
               state_d = cfg_burst_len == '0 || cfg_num_bursts == '0 ? DONE : WR_REQ;
            end
            WR_REQ, RD_REQ: begin
               idx_d = '0;
               lfsr_d = seed;
               if (app_req_ack) state_d = state_q == WR_REQ ? WR_DATA : RD_DATA;
            end
            WR_DATA: if (app_wr_next_req) begin
               idx_d = idx_q + 9'd1;
               lfsr_d = lfsr_nx;
               if (last) state_d = RD_REQ;
            end
            RD_DATA: if (app_rd_valid) begin
               idx_d = idx_q + 9'd1;
               lfsr_d = lfsr_nx;
               if (app_rd_data != word) begin
                  err_cnt_d = &err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1;
                  if (err_cnt_q == '0) first_err_addr_d = addr_q;
               end
               if (last) state_d = NEXT;
            end
            NEXT: if (b_q + 16'd1 == nb_q) begin
               state_d = DONE;
               done_d = 1'b1;
               pass_d = err_cnt_q == '0 && !timeout_q && !cfg_err_q;
            end else begin
               b_d = b_q + 16'd1;
               addr_d = addr_q + stride_q;
               state_d = WR_REQ;
            end
            default: ;
         endcase
         if (active && !progress && wdog_q == WDW'(TMO - 1)) begin
            state_d = DONE;
            timeout_d = 1'b1;
            done_d = 1'b1;
            pass_d = 1'b0;
         end
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         mode_q <= '0;
         addr_q <= '0;
         stride_q <= '0;
         len_q <= '0;
         nb_q <= '0;
         b_q <= '0;
         idx_q <= '0;
         lfsr_q <= '0;
         wdog_q <= '0;
         err_cnt_q <= '0;
         first_err_addr_q <= '0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
         timeout_q <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q <= mode_d;
         addr_q <= addr_d;
         stride_q <= stride_d;
         len_q <= len_d;
         nb_q <= nb_d;
         b_q <= b_d;
         idx_q <= idx_d;
         lfsr_q <= lfsr_d;
         wdog_q <= wdog_d;
         err_cnt_q <= err_cnt_d;
         first_err_addr_q <= first_err_addr_d;
         done_q <= done_d;
         pass_q <= pass_d;
         timeout_q <= timeout_d;
         cfg_err_q <= cfg_err_d;
      end
   end
endmodule

// File: tb/tb_sdrc_bist.sv
// tb_sdrc_bist: randomized bench for sdrc_bist. A reactive memory answers the DUT, and the
// expected addresses and words are computed directly from the pattern rules.
module tb_sdrc_bist;
   localparam int AW = 26, DW = 32, EW = 16, TMO = 64;
   logic clk = 0, reset_n = 1, start = 0, abort = 0;
   logic [1:0] cfg_mode = 0;
   logic [AW-1:0] cfg_start_addr = 0, cfg_addr_stride = 0;
   logic [8:0] cfg_burst_len = 0;
   logic [15:0] cfg_num_bursts = 0;
   logic app_req, app_req_wr_n, app_req_ack = 0, app_wr_next_req = 0, app_rd_valid = 0;
   logic [AW-1:0] app_req_addr, first_err_addr;
   logic [8:0] app_req_len;
   logic [DW-1:0] app_wr_data, app_rd_data = 0;
   logic [DW/8-1:0] app_wr_en_n;
   logic busy, done, pass, timeout, cfg_err;
   logic [EW-1:0] err_cnt;
   int vectors = 0, errors = 0, cyc = 0, n_req = 0, ack_cyc = 0;
   int k_max_delay = 3, k_fix_delay = -1, k_no_next = 0, k_abort_word = -1, k_reset_burst = -1;
   int k_poke = 0, k_cb = -1, k_cw = -1, k_cbit = 0;
   logic [AW-1:0] r_start, r_stride;
   logic [31:0] mem [int];

   sdrc_bist #(.APP_AW(AW), .APP_DW(DW), .ERR_W(EW), .TMO(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .cfg_mode(cfg_mode),
      .cfg_start_addr(cfg_start_addr), .cfg_addr_stride(cfg_addr_stride),
      .cfg_burst_len(cfg_burst_len), .cfg_num_bursts(cfg_num_bursts),
      .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
      .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack), .app_wr_data(app_wr_data),
      .app_wr_en_n(app_wr_en_n), .app_wr_next_req(app_wr_next_req), .app_rd_valid(app_rd_valid),
      .app_rd_data(app_rd_data), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .first_err_addr(first_err_addr), .timeout(timeout), .cfg_err(cfg_err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_word(input int b, input int i);
      logic [31:0] s = {b[15:0], ~b[15:0]};
      for (int k = 0; k < i; k++) s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
      return s;
   endfunction

   function automatic logic [31:0] exp_word(input int mode, input int b, input int i);
      logic [15:0] bb = b[15:0];
      case (mode)
         0: return {bb, 16'h0} + 32'(i);
         1: return lfsr_word(b, i);
         2: return 32'h1 << ((b + i) % 32);
         default: return (i % 2 == 1) ? 32'haaaa_aaaa : 32'h5555_5555;
      endcase
   endfunction

   function automatic logic [AW-1:0] exp_addr(input int b);
      longint a = longint'(r_start) + longint'(b) * longint'(r_stride);
      return a[AW-1:0];
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req"}, app_req, 0);
      chk({tag, "_wr_n"}, app_req_wr_n, 1);
      chk({tag, "_addr"}, app_req_addr, 0);
      chk({tag, "_len"}, app_req_len, 0);
      chk({tag, "_wdata"}, app_wr_data, 0);
      chk({tag, "_en_n"}, app_wr_en_n, 4'hf);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_err"}, err_cnt, 0);
      chk({tag, "_ferr"}, first_err_addr, 0);
      chk({tag, "_tmo"}, timeout, 0);
      chk({tag, "_cfgerr"}, cfg_err, 0);
   endtask

   task automatic run(input int mode, input int st, input int sd, input int len, input int nb);
      int b = 0, wi = 0, ri = 0, phase = 0, dly = -1, exp_err = 0, n;
      logic acked = 0, poked = 0, cfg_e, to_e;
      logic [AW-1:0] exp_first = '0;
      r_start = AW'(st);
      r_stride = AW'(sd);
      mem.delete();
      n_req = 0;
      cfg_mode = 2'(mode);
      cfg_start_addr = r_start;
      cfg_addr_stride = r_stride;
      cfg_burst_len = 9'(len);
      cfg_num_bursts = 16'(nb);
      start = 1;
      @(negedge clk);
      for (n = 0; n < 20000 && !done; n++) begin
         start = 0;
         app_req_ack = 0;
         app_wr_next_req = 0;
         app_rd_valid = 0;
         app_rd_data = '0;
         chk("busy_run", busy, 1);
         if (acked) chk("req_drop", app_req, 0);
         acked = 0;
         if ((phase == 0 || phase == 2) && app_req) begin
            chk("req_addr", app_req_addr, exp_addr(b));
            chk("req_wr_n", app_req_wr_n, phase == 2);
            chk("req_len", app_req_len, len);
            if (phase == 0 && b == k_reset_burst) begin
               chk("pre_reset_err", err_cnt, 1);
               reset_n = 0;
               #1;
               check_reset_vals("midreset");
               @(negedge clk);
               reset_n = 1;
               @(negedge clk);
               return;
            end
            if (dly < 0) dly = k_fix_delay >= 0 ? k_fix_delay : int'($urandom_range(k_max_delay, 0));
            if (dly == 0) begin
               app_req_ack = 1;
               acked = 1;
               dly = -1;
               phase++;
               n_req++;
               ack_cyc = cyc + 1;
            end else begin
               dly--;
               if (phase == 2 && $urandom_range(1, 0) == 1) begin
                  app_rd_valid = 1;
                  app_rd_data = $urandom;
               end
            end
         end else if (phase == 1) begin
            chk("wr_en_n", app_wr_en_n, 0);
            if (b == 1 && wi == k_abort_word) begin
               abort = 1;
               @(negedge clk);
               abort = 0;
               chk("abort_busy", busy, 0);
               chk("abort_req", app_req, 0);
               chk("abort_done", done, 0);
               chk("abort_en_n", app_wr_en_n, 4'hf);
               chk("abort_err_kept", err_cnt, 1);
               chk("abort_ferr_kept", first_err_addr, exp_addr(0));
               return;
            end
            if (k_poke != 0 && !poked) begin
               start = 1;
               cfg_mode = ~cfg_mode;
               cfg_burst_len = 9'd0;
               poked = 1;
            end
            if (k_no_next == 0 && $urandom_range(3, 0) != 0) begin
               chk("wr_data", app_wr_data, exp_word(mode, b, wi));
               mem[b * 512 + wi] = app_wr_data;
               app_wr_next_req = 1;
               wi++;
               if (wi == len) begin
                  wi = 0;
                  phase = 2;
               end
            end
         end else if (phase == 3 && $urandom_range(2, 0) != 0) begin
            app_rd_valid = 1;
            app_rd_data = mem[b * 512 + ri];
            if ((k_cb == -2 || b == k_cb) && ri == k_cw) begin
               app_rd_data[k_cbit] = ~app_rd_data[k_cbit];
               exp_err++;
               if (exp_err == 1) exp_first = exp_addr(b);
            end
            ri++;
            if (ri == len) begin
               ri = 0;
               phase = 0;
               b++;
            end
         end
         @(negedge clk);
      end
      start = 0;
      app_req_ack = 0;
      app_wr_next_req = 0;
      app_rd_valid = 0;
      cfg_e = len == 0;
      to_e = k_no_next != 0 && !cfg_e && nb != 0;
      chk("run_bounded", n < 20000, 1);
      chk("done", done, 1);
      chk("busy_end", busy, 0);
      chk("cfg_err", cfg_err, cfg_e);
      chk("timeout", timeout, to_e);
      chk("pass", pass, !cfg_e && !to_e && exp_err == 0);
      chk("err_cnt", err_cnt, exp_err);
      chk("first_err", first_err_addr, exp_first);
      chk("n_req", n_req, (cfg_e || nb == 0) ? 0 : to_e ? 1 : 2 * nb);
      if (to_e) chk("tmo_cycle", cyc - ack_cyc, TMO);
      @(negedge clk);
   endtask

   initial begin
      #2 reset_n = 0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset_n = 1;
      @(negedge clk);
      k_fix_delay = 5;
      run(0, 'h10000, 'h100, 5, 2);
      k_fix_delay = -1;
      k_cb = 7; k_cw = 2; k_cbit = 3;
      run(1, $urandom, $urandom_range(4095, 16), $urandom_range(8, 3), 20);
      k_cb = -1;
      k_poke = 1; k_max_delay = 5;
      run(2, $urandom, $urandom, $urandom_range(12, 1), $urandom_range(6, 1));
      run(3, $urandom, $urandom, $urandom_range(12, 1), $urandom_range(6, 1));
      k_poke = 0; k_max_delay = 3;
      k_cb = -2; k_cw = 0; k_cbit = $urandom_range(31, 0);
      run($urandom_range(3, 0), $urandom, $urandom, $urandom_range(9, 1), $urandom_range(5, 2));
      k_cb = -1;
      run(0, 'h3FF_FF00, 'h80, 4, 5);
      run(1, 0, 1, 0, 3);
      run(1, 0, 1, 4, 0);
      k_no_next = 1;
      run(0, 'h100, 'h10, 4, 3);
      k_no_next = 0;
      k_cb = 0; k_cw = 1; k_cbit = 0; k_abort_word = 2;
      run(3, $urandom, 'h40, 6, 4);
      k_abort_word = -1;
      k_cw = 0; k_reset_burst = 1;
      run(2, $urandom, 'h40, 4, 4);
      k_reset_burst = -1; k_cb = -1;
      run(1, $urandom, $urandom, $urandom_range(10, 1), $urandom_range(4, 1));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
